// File: rtl/msg_tx_pkg.sv
// Shared types and encodings for the serial message transmitter.
package msg_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_CONT    = 1'b1;
    localparam logic ORDER_MSB    = 1'b0;
    localparam logic ORDER_LSB    = 1'b1;

endpackage

// File: rtl/msg_tick_gen.sv
// Bit-time prescaler: counts 0..DIV-1 while enabled, tick asserted at DIV-1.
module msg_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count_q, count_d;

    assign tick = enable && (count_q == CW'(DIV - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = tick ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/msg_serial_tx.sv
// Serial message transmitter: one-shot or continuous, MSB/LSB-first, frame counter.
// Optional build macro PARITY_EN appends an even-parity bit to every frame.
module msg_serial_tx
    import msg_tx_pkg::*;
#(
    parameter int MSG_W     = 10,
    parameter int DIV       = 4,
    parameter int OUT_W     = 8,
    parameter int GAP_TICKS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [MSG_W-1:0] SW,
    input  logic             start,
    input  logic             mode,
    input  logic             sel,
    output logic             tx,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] out
);

`ifdef PARITY_EN
    localparam int FRAME_BITS = MSG_W + 1;
`else
    localparam int FRAME_BITS = MSG_W;
`endif
    localparam int CNT_MAX = (FRAME_BITS > GAP_TICKS) ? FRAME_BITS : GAP_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state_q, state_d;
    logic [MSG_W-1:0]   hold_q, hold_d;
    logic [MSG_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic               sel_q, sel_d;
    logic               stop_q, stop_d;
    logic               done_q, done_d;
    logic [OUT_W-1:0]   out_q, out_d;
`ifdef PARITY_EN
    logic               parity_q, parity_d;
`endif
    logic               tick_clear, tick_en, tick;
    logic               data_bit;

    msg_tick_gen #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clear  (tick_clear),
        .enable (tick_en),
        .tick   (tick)
    );

    always_comb begin
        data_bit = (sel_q == ORDER_LSB) ? shift_q[0] : shift_q[MSG_W-1];
`ifdef PARITY_EN
        if (cnt_q == CNT_W'(MSG_W)) data_bit = parity_q;
`endif
    end

    assign tx   = (state_q == SEND) ? data_bit : 1'b0;
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign out  = out_q;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        sel_d      = sel_q;
        stop_d     = stop_q;
        done_d     = 1'b0;
        out_d      = out_q;
`ifdef PARITY_EN
        parity_d   = parity_q;
`endif
        tick_clear = 1'b0;
        tick_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (init) begin
                    hold_d = SW;
                end else if (start) begin
                    shift_d    = hold_q;
                    mode_d     = mode;
                    sel_d      = sel;
                    cnt_d      = '0;
                    stop_d     = 1'b0;
                    tick_clear = 1'b1;
                    state_d    = SEND;
`ifdef PARITY_EN
                    parity_d   = ^hold_q;
`endif
                end
            end
            SEND: begin
                tick_en = 1'b1;
                if (start && mode_q == MODE_CONT) stop_d = 1'b1;
                if (tick) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    shift_d = (sel_q == ORDER_LSB) ? (shift_q >> 1) : (shift_q << 1);
                    if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        done_d = 1'b1;
                        out_d  = out_q + OUT_W'(1);
                        cnt_d  = '0;
                        // stop_d (not stop_q) so a stop arriving on the final edge still ends the run
                        if (mode_q == MODE_ONESHOT || stop_d) begin
                            state_d = IDLE;
                            stop_d  = 1'b0;
                        end else begin
                            state_d = GAP;
                        end
                    end
                end
            end
            GAP: begin
                tick_en = 1'b1;
                if (start) stop_d = 1'b1;
                if (tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(GAP_TICKS - 1)) begin
                        cnt_d = '0;
                        if (stop_d) begin
                            state_d = IDLE;
                            stop_d  = 1'b0;
                        end else begin
                            shift_d  = hold_q;
                            state_d  = SEND;
`ifdef PARITY_EN
                            parity_d = ^hold_q;
`endif
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            shift_q  <= '0;
            cnt_q    <= '0;
            mode_q   <= MODE_ONESHOT;
            sel_q    <= ORDER_MSB;
            stop_q   <= 1'b0;
            done_q   <= 1'b0;
            out_q    <= '0;
`ifdef PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            sel_q    <= sel_d;
            stop_q   <= stop_d;
            done_q   <= done_d;
            out_q    <= out_d;
`ifdef PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
